// File: rtl/lsq_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types : shared LSQ/ROB types, controller states, funct3 codes. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package rv32i_types;

  localparam int ROB_NUM_BITS  = 4;
  localparam int PHYS_REG_BITS = 6;

  typedef logic [ROB_NUM_BITS-1:0] rob_num_t;

  typedef struct packed {
    logic                     is_store;
    logic [2:0]               funct3;
    logic [31:0]              addr;
    logic [31:0]              wdata;
    rob_num_t                 rob_num;
    logic [PHYS_REG_BITS-1:0] pd;
  } lsq_entry_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_COMMIT = 2'd1,
    REQ         = 2'd2,
    DRAIN       = 2'd3
  } lsq_ctrl_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

`default_nettype wire

// File: rtl/lsq_mem_ctrl_mem_align.sv
// ---------------------------------------------------------------------------
// mem_align : byte-lane masks, store-data shift and load extraction. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_value_o
);

  logic [31:0] rdata_shifted;

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   mask_o = 4'b0001 << offset_i;
      2'b01:   mask_o = 4'b0011 << offset_i;
      default: mask_o = 4'b1111;
    endcase
  end

  assign wdata_o       = wdata_i << {offset_i, 3'b000};
  assign rdata_shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    case (funct3_i)
      LB:      load_value_o = {{24{rdata_shifted[7]}},  rdata_shifted[7:0]};
      LH:      load_value_o = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      LBU:     load_value_o = {24'h0, rdata_shifted[7:0]};
      LHU:     load_value_o = {16'h0, rdata_shifted[15:0]};
      LW:      load_value_o = rdata_shifted;
      default: load_value_o = rdata_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsq_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsq_mem_ctrl : sequences LSQ head entries onto the data-cache port. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module lsq_mem_ctrl
  import rv32i_types::*;
#(
  parameter int ROB_BITS  = ROB_NUM_BITS,
  parameter int PHYS_BITS = PHYS_REG_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mispredict,
  input  logic                 lsq_empty,
  input  lsq_entry_t           head_entry,
  input  rob_num_t             rob_head,
  input  logic                 rob_head_valid,
  output logic                 lsq_pop,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp,
  output logic                 cdb_valid,
  output logic [ROB_BITS-1:0]  cdb_rob,
  output logic [PHYS_BITS-1:0] cdb_pd,
  output logic [31:0]          cdb_value,
  output logic                 store_done
);

  lsq_ctrl_state_t state_q, state_d;
  lsq_entry_t      cur_q, cur_d;
  logic            flush_q, flush_d;

  logic                 cdb_valid_q;
  logic [ROB_BITS-1:0]  cdb_rob_q;
  logic [PHYS_BITS-1:0] cdb_pd_q;
  logic [31:0]          cdb_value_q;
  logic                 cdb_load;

  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [31:0] load_value;

  mem_align u_mem_align (
    .funct3_i     (cur_q.funct3),
    .offset_i     (cur_q.addr[1:0]),
    .wdata_i      (cur_q.wdata),
    .rdata_i      (dmem_rdata),
    .mask_o       (lane_mask),
    .wdata_o      (lane_wdata),
    .load_value_o (load_value)
  );

  // The request is a pure function of cur_q, so it stays stable until resp.
  always_comb begin
    dmem_addr  = 32'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
    dmem_wdata = 32'h0;
    if (state_q == REQ || state_q == DRAIN) begin
      dmem_addr = {cur_q.addr[31:2], 2'b00};
      if (cur_q.is_store) begin
        dmem_wmask = lane_mask;
        dmem_wdata = lane_wdata;
      end else begin
        dmem_rmask = lane_mask;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    flush_d    = flush_q;
    lsq_pop    = 1'b0;
    store_done = 1'b0;
    cdb_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mispredict && !lsq_empty) begin
          cur_d = head_entry;
          if (!head_entry.is_store ||
              (rob_head_valid && rob_head == head_entry.rob_num)) begin
            state_d = REQ;
          end else begin
            state_d = WAIT_COMMIT;
          end
        end
      end
      WAIT_COMMIT: begin
        if (mispredict) begin
          state_d = IDLE;
        end else if (rob_head_valid && rob_head == cur_q.rob_num) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (dmem_resp) begin
          state_d    = IDLE;
          flush_d    = 1'b0;
          lsq_pop    = !mispredict && !flush_q;
          store_done = cur_q.is_store;
          cdb_load   = !cur_q.is_store && !mispredict;
        end else if (mispredict) begin
          // A committed store must still land; only its queue pop is lost.
          if (cur_q.is_store) begin
            flush_d = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (dmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      flush_q     <= 1'b0;
      cdb_valid_q <= 1'b0;
      cdb_rob_q   <= '0;
      cdb_pd_q    <= '0;
      cdb_value_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      flush_q     <= flush_d;
      cdb_valid_q <= cdb_load;
      if (cdb_load) begin
        cdb_rob_q   <= cur_q.rob_num;
        cdb_pd_q    <= cur_q.pd;
        cdb_value_q <= load_value;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_rob   = cdb_rob_q;
  assign cdb_pd    = cdb_pd_q;
  assign cdb_value = cdb_value_q;

endmodule

`default_nettype wire

// File: tb/tb_lsq_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsq_mem_ctrl : scoreboard bench for lsq_mem_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lsq_mem_ctrl;
  import rv32i_types::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    rob_num_t                 rob;
    logic [PHYS_REG_BITS-1:0] pd;
    logic [31:0]              value;
  } cdb_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     mispredict = 1'b0;
  logic                     lsq_empty = 1'b1;
  lsq_entry_t               head_entry = '0;
  rob_num_t                 rob_head = '0;
  logic                     rob_head_valid = 1'b0;
  logic                     lsq_pop;
  logic [31:0]              dmem_addr;
  logic [3:0]               dmem_rmask;
  logic [3:0]               dmem_wmask;
  logic [31:0]              dmem_wdata;
  logic [31:0]              dmem_rdata = 32'h0;
  logic                     dmem_resp = 1'b0;
  logic                     cdb_valid;
  rob_num_t                 cdb_rob;
  logic [PHYS_REG_BITS-1:0] cdb_pd;
  logic [31:0]              cdb_value;
  logic                     store_done;

  int checks = 0;
  int errors = 0;

  req_t       req_q[$];
  cdb_t       cdb_q[$];
  bit         pop_q[$];
  int         sd_pending = 0;
  lsq_entry_t lsq[$];
  logic [31:0] mem [logic [31:0]];
  int         lat = 1;
  bit         pop_seen = 1'b0;

  lsq_mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .mispredict     (mispredict),
    .lsq_empty      (lsq_empty),
    .head_entry     (head_entry),
    .rob_head       (rob_head),
    .rob_head_valid (rob_head_valid),
    .lsq_pop        (lsq_pop),
    .dmem_addr      (dmem_addr),
    .dmem_rmask     (dmem_rmask),
    .dmem_wmask     (dmem_wmask),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_resp      (dmem_resp),
    .cdb_valid      (cdb_valid),
    .cdb_rob        (cdb_rob),
    .cdb_pd         (cdb_pd),
    .cdb_value      (cdb_value),
    .store_done     (store_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  function automatic lsq_entry_t mk(input logic st, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    input rob_num_t rb, input logic [PHYS_REG_BITS-1:0] p);
    lsq_entry_t e;
    e.is_store = st;
    e.funct3   = f3;
    e.addr     = a;
    e.wdata    = wd;
    e.rob_num  = rb;
    e.pd       = p;
    return e;
  endfunction

  // Cache model: answers the lat-th cycle of a visible request.
  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (dmem_rmask != 4'h0 || dmem_wmask != 4'h0)) begin
        cnt++;
        if (cnt >= lat) begin
          dmem_resp  = 1'b1;
          dmem_rdata = mem.exists(dmem_addr) ? mem[dmem_addr] : 32'h0;
          cnt = 0;
        end else begin
          dmem_resp = 1'b0;
        end
      end else begin
        cnt = 0;
        dmem_resp = 1'b0;
      end
    end
  end

  // Queue model: presents lsq[0] as the head and retires it on a pop.
  initial begin : lsq_model
    forever begin
      @(posedge clk);
      #1;
      if (pop_seen && lsq.size() > 0) void'(lsq.pop_front());
      pop_seen   = 1'b0;
      lsq_empty  = (lsq.size() == 0);
      head_entry = (lsq.size() > 0) ? lsq[0] : '0;
    end
  end

  initial begin : monitor
    bit   prev_busy;
    bit   exp_cdb;
    bit   busy;
    bit   flag;
    req_t held;
    req_t cur;
    req_t er;
    cdb_t ec;
    prev_busy = 1'b0;
    exp_cdb   = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        exp_cdb   = 1'b0;
        continue;
      end
      cur.addr  = dmem_addr;
      cur.rmask = dmem_rmask;
      cur.wmask = dmem_wmask;
      cur.wdata = dmem_wdata;
      busy = (dmem_rmask != 4'h0) || (dmem_wmask != 4'h0);
      if (busy) begin
        if (dmem_rmask != 4'h0 && dmem_wmask != 4'h0) fail_evt("both_masks");
        if (!prev_busy) begin
          if (req_q.size() == 0) begin
            fail_evt("unexpected_request");
          end else begin
            er = req_q.pop_front();
            chk("req_addr", dmem_addr, er.addr);
            chk("req_masks", {24'h0, dmem_rmask, dmem_wmask}, {24'h0, er.rmask, er.wmask});
            chk("req_wdata", dmem_wdata, er.wdata);
          end
          held = cur;
        end else begin
          chk("req_stable", {31'h0, cur == held}, 32'h1);
        end
      end
      if (cdb_valid || exp_cdb) chk("cdb_timing", {31'h0, cdb_valid}, {31'h0, exp_cdb});
      if (cdb_valid) begin
        if (cdb_q.size() == 0) begin
          fail_evt("unexpected_cdb");
        end else begin
          ec = cdb_q.pop_front();
          chk("cdb_rob", {28'h0, cdb_rob}, {28'h0, ec.rob});
          chk("cdb_pd", {26'h0, cdb_pd}, {26'h0, ec.pd});
          chk("cdb_value", cdb_value, ec.value);
        end
      end
      exp_cdb = lsq_pop && (dmem_rmask != 4'h0);
      if (lsq_pop) begin
        chk("pop_with_resp", {31'h0, dmem_resp}, 32'h1);
        if (pop_q.size() == 0) begin
          fail_evt("unexpected_pop");
        end else begin
          flag = pop_q.pop_front();
          chk("store_done_with_pop", {31'h0, store_done}, {31'h0, flag});
        end
        pop_seen = 1'b1;
      end
      if (store_done) begin
        if (sd_pending == 0) fail_evt("unexpected_store_done");
        else begin
          sd_pending--;
          chk("store_done_with_resp", {31'h0, dmem_resp}, 32'h1);
        end
      end
      prev_busy = busy && !dmem_resp;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (req_q.size() == 0 && cdb_q.size() == 0 && pop_q.size() == 0 &&
          sd_pending == 0 && lsq.size() == 0 && dmem_rmask == 4'h0 &&
          dmem_wmask == 4'h0 && !cdb_valid) begin
        ok = 1'b1;
        break;
      end
    end
    cyc(3);
    chk(name, {31'h0, ok}, 32'h1);
  endtask

  task automatic wait_req(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (dmem_rmask != 4'h0 || dmem_wmask != 4'h0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk(name, 32'h0, 32'h1);
  endtask

  task automatic flush_pulse();
    mispredict = 1'b1;
    lsq.delete();
    lsq_empty  = 1'b1;
    head_entry = '0;
    cyc(1);
    mispredict = 1'b0;
  endtask

  task automatic quiet_cycles(input string name, input int n);
    repeat (n) begin
      @(negedge clk);
      chk(name, {23'h0, lsq_pop, store_done, dmem_rmask, dmem_wmask}, 32'h0);
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : stimulus
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pop_done", {30'h0, lsq_pop, store_done}, 32'h0);
    chk("rst_masks", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_cdb_valid", {31'h0, cdb_valid}, 32'h0);
    chk("rst_cdb_value", cdb_value, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc(2);

    // lw, 3-cycle latency
    mem[32'h100] = 32'hDEADBEEF;
    lat = 3;
    req_q.push_back('{32'h100, 4'hF, 4'h0, 32'h0});
    pop_q.push_back(1'b0);
    cdb_q.push_back('{4'd5, 6'd12, 32'hDEADBEEF});
    lsq.push_back(mk(1'b0, LW, 32'h100, 32'h0, 4'd5, 6'd12));
    wait_done("lw_done");

    // lb / lbu on the top byte lane
    mem[32'h100] = 32'h80FFFFFF;
    lat = 2;
    req_q.push_back('{32'h100, 4'h8, 4'h0, 32'h0});
    pop_q.push_back(1'b0);
    cdb_q.push_back('{4'd1, 6'd2, 32'hFFFFFF80});
    lsq.push_back(mk(1'b0, LB, 32'h103, 32'h0, 4'd1, 6'd2));
    wait_done("lb_done");
    req_q.push_back('{32'h100, 4'h8, 4'h0, 32'h0});
    pop_q.push_back(1'b0);
    cdb_q.push_back('{4'd2, 6'd3, 32'h00000080});
    lsq.push_back(mk(1'b0, LBU, 32'h103, 32'h0, 4'd2, 6'd3));
    wait_done("lbu_done");

    // sh held until it reaches the ROB head
    rob_head_valid = 1'b1;
    rob_head = 4'd3;
    req_q.push_back('{32'h200, 4'h0, 4'hC, 32'h12340000});
    pop_q.push_back(1'b1);
    sd_pending++;
    lsq.push_back(mk(1'b1, SH, 32'h202, 32'h1234, 4'd7, 6'd0));
    quiet_cycles("sh_gated", 4);
    rob_head = 4'd7;
    wait_done("sh_done");

    // mispredict while a load is in flight: drained, no pop, no broadcast
    lat = 4;
    mem[32'h300] = 32'h00000077;
    req_q.push_back('{32'h300, 4'hF, 4'h0, 32'h0});
    lsq.push_back(mk(1'b0, LW, 32'h300, 32'h0, 4'd2, 6'd3));
    wait_req("drain_req_seen");
    flush_pulse();
    wait_done("drain_done");

    // mispredict while a store waits for commit
    rob_head = 4'd3;
    lsq.push_back(mk(1'b1, SW, 32'h400, 32'h55, 4'd9, 6'd0));
    cyc(3);
    flush_pulse();
    rob_head = 4'd9;
    quiet_cycles("wc_flush_quiet", 4);
    wait_done("wc_flush_done");

    // mispredict during a committed store: write lands, no pop
    lat = 3;
    rob_head = 4'd4;
    req_q.push_back('{32'h500, 4'h0, 4'hF, 32'hA5A5A5A5});
    sd_pending++;
    lsq.push_back(mk(1'b1, SW, 32'h500, 32'hA5A5A5A5, 4'd4, 6'd0));
    wait_req("st_flush_req_seen");
    flush_pulse();
    wait_done("st_flush_done");

    // back-to-back lw, lw, sw with 1-cycle latency
    lat = 1;
    rob_head = 4'd3;
    mem[32'h600] = 32'h11111111;
    mem[32'h604] = 32'h22222222;
    req_q.push_back('{32'h600, 4'hF, 4'h0, 32'h0});
    req_q.push_back('{32'h604, 4'hF, 4'h0, 32'h0});
    req_q.push_back('{32'h608, 4'h0, 4'hF, 32'hCAFEF00D});
    pop_q.push_back(1'b0);
    pop_q.push_back(1'b0);
    pop_q.push_back(1'b1);
    cdb_q.push_back('{4'd1, 6'd1, 32'h11111111});
    cdb_q.push_back('{4'd2, 6'd2, 32'h22222222});
    sd_pending++;
    lsq.push_back(mk(1'b0, LW, 32'h600, 32'h0, 4'd1, 6'd1));
    lsq.push_back(mk(1'b0, LW, 32'h604, 32'h0, 4'd2, 6'd2));
    lsq.push_back(mk(1'b1, SW, 32'h608, 32'hCAFEF00D, 4'd3, 6'd0));
    wait_done("b2b_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
